mem_access_unit: RTL and testbench

Parametrised load/store memory stage between the EX/MEM pipeline register and MEM/WB. It holds each instruction in an internal FSM and runs a valid/ready request plus a valid response exchange with the data cache. It aligns and sign- or zero-extends load data by address byte offset and generates store byte strobes. Results go to writeback and the forwarding path, with a stall flag back to the pipeline.

---
 rtl/mem_access_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store memory stage: holds one instruction, runs a valid/ready request plus response with the data cache.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses trap instead of being issued size-aligned.
module mem_access_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                wreg_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [XLEN-1:0]     store_data_i,
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic [ADDR_W-1:0]   dc_req_addr,
  output logic                dc_req_we,
  output logic [XLEN/8-1:0]   dc_req_wstrb,
  output logic [XLEN-1:0]     dc_req_wdata,
  input  logic                dc_resp_valid,
  input  logic [XLEN-1:0]     dc_resp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          rd_addr_o,
  output logic                wreg_o,
  output logic [XLEN-1:0]     wdata_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                misalign_o,
  output logic                block_flag_o,
  output logic [4:0]          back_rd_addr_o,
  output logic                back_wreg_o,
  output logic [XLEN-1:0]     back_wdata_o
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [4:0]          rd_addr_q, rd_addr_d;
  logic                wreg_q, wreg_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                is_store_q, is_store_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                req_we_q, req_we_d;
  logic [STRB_W-1:0]   req_wstrb_q, req_wstrb_d;
  logic [XLEN-1:0]     req_wdata_q, req_wdata_d;

  logic                is_load, is_store, is_mem;
  logic [ADDR_W-1:0]   eff_addr;
  logic [OFF_W-1:0]    off_raw, off_al, align_mask;
  logic [STRB_W-1:0]   strb_base;
  logic [XLEN-1:0]     shifted, load_val;

  // The effective address arrives on the XLEN-wide ALU result bus.
  generate
    if (ADDR_W == XLEN) begin : g_addr_eq
      assign eff_addr = wdata_i;
    end else if (ADDR_W > XLEN) begin : g_addr_zext
      assign eff_addr = {{(ADDR_W-XLEN){1'b0}}, wdata_i};
    end else begin : g_addr_trunc
      assign eff_addr = wdata_i[ADDR_W-1:0];
    end
  endgenerate

  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign is_mem   = is_load | is_store;
  assign off_raw  = eff_addr[OFF_W-1:0];

  always_comb begin
    align_mask = '0;
    strb_base  = '0;
    case (funct3_i[1:0])
      2'd0: begin align_mask = '0;          strb_base = STRB_W'(8'h01); end
      2'd1: begin align_mask = OFF_W'(1);   strb_base = STRB_W'(8'h03); end
      2'd2: begin align_mask = OFF_W'(3);   strb_base = STRB_W'(8'h0F); end
      default: begin align_mask = OFF_W'(7); strb_base = '1; end
    endcase
  end

  // Without trapping, a misaligned offset is rounded down to the access size.
  assign off_al = off_raw & ~align_mask;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q, misalign_d;
  assign misaligned = ((off_raw & align_mask) != '0);
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign shifted = dc_resp_data >> {off_q, 3'b000};

  always_comb begin
    load_val = '0;
    case (funct3_q)
      3'b000: load_val = XLEN'($signed(shifted[7:0]));
      3'b100: load_val = XLEN'(shifted[7:0]);
      3'b001: load_val = XLEN'($signed(shifted[15:0]));
      3'b101: load_val = XLEN'(shifted[15:0]);
      3'b010: load_val = XLEN'($signed(shifted[31:0]));
      3'b110: if (XLEN == 64) load_val = XLEN'(shifted[31:0]);
      3'b011: if (XLEN == 64) load_val = shifted;
      default: load_val = '0;
    endcase
  end

  assign out_valid    = (state_q == S_DONE);
  assign in_ready     = (state_q == S_IDLE) & (~out_valid | out_ready);
  assign block_flag_o = ~in_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rd_addr_d   = rd_addr_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    off_d       = off_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          pc_d       = pc_i;
          rd_addr_d  = rd_addr_i;
          wreg_d     = wreg_i;
          funct3_d   = funct3_i;
          is_store_d = is_store;
          wdata_d    = wdata_i;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_d = 1'b0;
`endif
          if (!is_mem) begin
            state_d = S_DONE;
`ifdef MEM_MISALIGN_TRAP_EN
          end else if (misaligned) begin
            // Trap result carries the faulting address and never writes a register.
            misalign_d = 1'b1;
            wreg_d     = 1'b0;
            state_d    = S_DONE;
`endif
          end else begin
            off_d       = off_al;
            req_addr_d  = {eff_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            req_we_d    = is_store;
            req_wstrb_d = is_store ? (strb_base << off_al) : '0;
            req_wdata_d = is_store ? (store_data_i << {off_al, 3'b000}) : '0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dc_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dc_resp_valid) begin
          if (is_store_q) begin
            wdata_d = '0;
            wreg_d  = 1'b0;
          end else begin
            wdata_d = load_val;
          end
          state_d = S_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      rd_addr_q   <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      off_q       <= '0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_addr_q   <= rd_addr_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      off_q       <= off_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign dc_req_valid   = (state_q == S_REQ);
  assign dc_req_addr    = req_addr_q;
  assign dc_req_we      = req_we_q;
  assign dc_req_wstrb   = req_wstrb_q;
  assign dc_req_wdata   = req_wdata_q;
  assign rd_addr_o      = rd_addr_q;
  assign wreg_o         = wreg_q;
  assign wdata_o        = wdata_q;
  assign pc_o           = pc_q;
  assign back_rd_addr_o = rd_addr_q;
  assign back_wreg_o    = wreg_q & out_valid;
  assign back_wdata_o   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (XLEN=64, ADDR_W=64).
module tb_mem_access_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] pc_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_addr_i;
  logic        wreg_i;
  logic [63:0] wdata_i, store_data_i;
  logic        dc_req_valid, dc_req_ready;
  logic [63:0] dc_req_addr;
  logic        dc_req_we;
  logic [7:0]  dc_req_wstrb;
  logic [63:0] dc_req_wdata;
  logic        dc_resp_valid;
  logic [63:0] dc_resp_data;
  logic        out_valid, out_ready;
  logic [4:0]  rd_addr_o;
  logic        wreg_o;
  logic [63:0] wdata_o, pc_o;
  logic        misalign_o, block_flag_o;
  logic [4:0]  back_rd_addr_o;
  logic        back_wreg_o;
  logic [63:0] back_wdata_o;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .opcode_i(opcode_i),
    .funct3_i(funct3_i), .rd_addr_i(rd_addr_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .store_data_i(store_data_i),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_we(dc_req_we), .dc_req_wstrb(dc_req_wstrb), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .rd_addr_o(rd_addr_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .pc_o(pc_o), .misalign_o(misalign_o), .block_flag_o(block_flag_o),
    .back_rd_addr_o(back_rd_addr_o), .back_wreg_o(back_wreg_o), .back_wdata_o(back_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one memory op against a zero-wait cache; returns with the DUT in DONE.
  task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [63:0] resp);
    in_valid = 1'b1; opcode_i = op; funct3_i = f3; wdata_i = addr;
    store_data_i = sdata; wreg_i = 1'b1; rd_addr_i = 5'd9; pc_i = 64'h200;
    step();
    in_valid = 1'b0;
    step();
    dc_resp_valid = 1'b1; dc_resp_data = resp;
    step();
    dc_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'b011; wdata_i = 64'hFF;
    store_data_i = 64'h1; wreg_i = 1'b1; rd_addr_i = 5'd3; pc_i = 64'h44;
    out_ready = 1'b1; dc_req_ready = 1'b1; dc_resp_valid = 1'b0; dc_resp_data = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", dc_req_valid); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
    checks++; if (wdata_o !== 64'h0 || dc_req_wstrb !== 8'h0 || dc_req_addr !== 64'h0) begin
      errors++; $display("FAIL reset_data: wdata_o=%h wstrb=%h addr=%h want all 0", wdata_o, dc_req_wstrb, dc_req_addr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b0; rst_n = 1'b1;
    step();
    $display("reset: out_valid=%b req_valid=%b in_ready=%b", out_valid, dc_req_valid, in_ready);
  endtask

  task automatic test_alu();
    in_valid = 1'b1; opcode_i = OP_ALU; funct3_i = 3'b000; wdata_i = 64'h1234;
    wreg_i = 1'b1; rd_addr_i = 5'd5; pc_i = 64'h80; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wdata_o !== 64'h1234) begin
      errors++; $display("FAIL alu_result: out_valid=%b wdata_o=%h want 1 / 1234", out_valid, wdata_o); end
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b want 0", dc_req_valid); end
    checks++; if (rd_addr_o !== 5'd5 || pc_o !== 64'h80 || back_wreg_o !== 1'b1 || back_wdata_o !== 64'h1234) begin
      errors++; $display("FAIL alu_fields: rd=%0d pc=%h bwreg=%b bwdata=%h want 5/80/1/1234", rd_addr_o, pc_o, back_wreg_o, back_wdata_o); end
    $display("alu: wdata_o=%h rd=%0d", wdata_o, rd_addr_o);
    step();
    checks++; if (out_valid !== 1'b0 || back_wreg_o !== 1'b0) begin
      errors++; $display("FAIL alu_release: out_valid=%b back_wreg=%b want 0/0", out_valid, back_wreg_o); end
  endtask

  task automatic test_load();
    logic [2:0]  f3_t  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b111};
    logic [63:0] adr_t [8] = '{64'h1003, 64'h1003, 64'h1006, 64'h1006, 64'h1004, 64'h1004, 64'h1000, 64'h1000};
    logic [63:0] rsp_t [8] = '{64'h00000000_80000000, 64'h00000000_80000000,
                               64'h8001_0000_0000_0000, 64'h8001_0000_0000_0000,
                               64'hDEADBEEF_00000000, 64'hDEADBEEF_00000000,
                               64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF};
    logic [63:0] exp_t [8] = '{64'hFFFFFFFF_FFFFFF80, 64'h00000000_00000080,
                               64'hFFFFFFFF_FFFF8001, 64'h00000000_00008001,
                               64'hFFFFFFFF_DEADBEEF, 64'h00000000_DEADBEEF,
                               64'h01234567_89ABCDEF, 64'h00000000_00000000};
    for (int i = 0; i < 8; i++) begin
      mem_op(OP_LOAD, f3_t[i], adr_t[i], 64'h0, rsp_t[i]);
      checks++; if (out_valid !== 1'b1 || wdata_o !== exp_t[i] || wreg_o !== 1'b1) begin
        errors++; $display("FAIL load_%0d f3=%b: out_valid=%b wdata_o=%h wreg=%b want 1 %h 1",
                           i, f3_t[i], out_valid, wdata_o, wreg_o, exp_t[i]); end
      $display("load f3=%b addr=%h resp=%h -> %h", f3_t[i], adr_t[i], rsp_t[i], wdata_o);
      step();
    end
  endtask

  task automatic test_store();
    in_valid = 1'b1; opcode_i = OP_STORE; funct3_i = 3'b001; wdata_i = 64'h1006;
    store_data_i = 64'hBEEF; wreg_i = 1'b1; rd_addr_i = 5'd1;
    step();
    in_valid = 1'b0;
    checks++; if (dc_req_valid !== 1'b1 || dc_req_we !== 1'b1 || dc_req_addr !== 64'h1000) begin
      errors++; $display("FAIL store_req: valid=%b we=%b addr=%h want 1/1/1000", dc_req_valid, dc_req_we, dc_req_addr); end
    checks++; if (dc_req_wstrb !== 8'hC0 || dc_req_wdata !== 64'hBEEF0000_00000000) begin
      errors++; $display("FAIL store_lanes: wstrb=%h wdata=%h want c0/beef000000000000", dc_req_wstrb, dc_req_wdata); end
    step();
    dc_resp_valid = 1'b1; dc_resp_data = 64'h55;
    step();
    dc_resp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wreg_o !== 1'b0 || wdata_o !== 64'h0 || back_wreg_o !== 1'b0) begin
      errors++; $display("FAIL store_result: out_valid=%b wreg=%b wdata=%h bwreg=%b want 1/0/0/0", out_valid, wreg_o, wdata_o, back_wreg_o); end
    $display("store sh addr=1006: wstrb=%h wreg_o=%b", 8'hC0, wreg_o);
    step();
  endtask

  task automatic test_req_stall();
    dc_req_ready = 1'b0;
    in_valid = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'b010; wdata_i = 64'h1008; wreg_i = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 64'h1008 || block_flag_o !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL stall_cycle_%0d: valid=%b addr=%h block=%b out_valid=%b want 1/1008/1/0",
                           c, dc_req_valid, dc_req_addr, block_flag_o, out_valid); end
      step();
    end
    dc_req_ready = 1'b1;
    step();
    checks++; if (dc_req_valid !== 1'b0 || block_flag_o !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_wait: valid=%b block=%b out_valid=%b want 0/1/0", dc_req_valid, block_flag_o, out_valid); end
    dc_resp_valid = 1'b1; dc_resp_data = 64'h12345678_7FFFFFFF;
    step();
    dc_resp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wdata_o !== 64'h7FFFFFFF) begin
      errors++; $display("FAIL stall_result: out_valid=%b wdata=%h want 1/7fffffff", out_valid, wdata_o); end
    $display("stall: lw after 5 wait cycles -> %h", wdata_o);
    step();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; opcode_i = OP_ALU; wdata_i = 64'hAAAA; wreg_i = 1'b1; rd_addr_i = 5'd2;
    step();
    out_ready = 1'b0; wdata_i = 64'h5555; rd_addr_i = 5'd4;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b1 || wdata_o !== 64'hAAAA || in_ready !== 1'b0 || block_flag_o !== 1'b1) begin
        errors++; $display("FAIL hold_cycle_%0d: out_valid=%b wdata=%h in_ready=%b block=%b want 1/aaaa/0/1",
                           c, out_valid, wdata_o, in_ready, block_flag_o); end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wdata_o !== 64'h5555 || rd_addr_o !== 5'd4) begin
      errors++; $display("FAIL second_result: out_valid=%b wdata=%h rd=%0d want 1/5555/4", out_valid, wdata_o, rd_addr_o); end
    $display("back_to_back: second result %h", wdata_o);
    step();
  endtask

  task automatic test_misalign();
    in_valid = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'b010; wdata_i = 64'h1002; wreg_i = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (out_valid !== 1'b1 || dc_req_valid !== 1'b0 || misalign_o !== 1'b1) begin
      errors++; $display("FAIL trap_state: out_valid=%b req=%b misalign=%b want 1/0/1", out_valid, dc_req_valid, misalign_o); end
    checks++; if (wdata_o !== 64'h1002 || wreg_o !== 1'b0) begin
      errors++; $display("FAIL trap_data: wdata=%h wreg=%b want 1002/0", wdata_o, wreg_o); end
    $display("misalign trap: wdata_o=%h", wdata_o);
    step();
`else
    checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 64'h1000 || misalign_o !== 1'b0) begin
      errors++; $display("FAIL misalign_req: req=%b addr=%h misalign=%b want 1/1000/0", dc_req_valid, dc_req_addr, misalign_o); end
    step();
    dc_resp_valid = 1'b1; dc_resp_data = 64'hAAAABBBB_11223344;
    step();
    dc_resp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wdata_o !== 64'h11223344 || misalign_o !== 1'b0) begin
      errors++; $display("FAIL misalign_data: out_valid=%b wdata=%h misalign=%b want 1/11223344/0", out_valid, wdata_o, misalign_o); end
    $display("misalign issued aligned: wdata_o=%h", wdata_o);
    step();
`endif
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'b011; wdata_i = 64'h2000;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (dc_req_valid !== 1'b0 || out_valid !== 1'b0 || wdata_o !== 64'h0) begin
      errors++; $display("FAIL mid_reset: req=%b out_valid=%b wdata=%h want 0/0/0", dc_req_valid, out_valid, wdata_o); end
    dc_resp_valid = 1'b1; dc_resp_data = 64'hDEAD;
    step();
    dc_resp_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stray_resp: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    $display("reset mid-transaction: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_req_stall();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
